// File: rtl/fetch_queue.sv
// Fetch queue between the program counter, instruction memory and decode.
// Entries are allocated in order when a fetch is accepted and filled in order
// by the memory's in-order responses. A flush empties the queue immediately;
// responses still in flight for the squashed fetches are counted in drop_q
// and swallowed in the DRAIN state before fetching resumes.
module fetch_queue #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PC_WIDTH-1:0]    pc_in,
  output logic                   pc_en,
  input  logic                   flush,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [INSTR_WIDTH-1:0] id_instr,
  output logic [PC_WIDTH-1:0]    id_pc,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {RUN, DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          head_q, head_d;   // oldest entry (pop side)
  logic [AW-1:0]          tail_q, tail_d;   // next entry to allocate
  logic [AW-1:0]          fptr_q, fptr_d;   // oldest allocated-but-unfilled entry
  logic [CW-1:0]          count_q, count_d; // allocated entries
  logic [CW-1:0]          pend_q, pend_d;   // allocated entries awaiting a response
  logic [CW-1:0]          drop_q, drop_d;   // in-flight responses to discard
  logic [DEPTH-1:0]       fill_q;
  logic [PC_WIDTH-1:0]    pc_mem  [DEPTH];
  logic [INSTR_WIDTH-1:0] ins_mem [DEPTH];

  logic alloc, pop, rv_drop, rv_fill;

  // Request/handshake decode; responses retire squashed fetches before live ones
  always_comb begin
    imem_addr = pc_in;
    imem_req  = ~rst & (state_q == RUN) & ~flush & (count_q < CW'(DEPTH));
    alloc     = imem_req & imem_gnt;
    pc_en     = alloc | flush;
    id_valid  = fill_q[head_q] & ~flush;
    id_instr  = ins_mem[head_q];
    id_pc     = pc_mem[head_q];
    count     = count_q;
    pop       = id_valid & id_ready;
    rv_drop   = imem_rvalid & (drop_q != '0);
    rv_fill   = imem_rvalid & (drop_q == '0) & (pend_q != '0);
  end

  // Next-state for pointers, counters and drain FSM
  always_comb begin
    head_d  = head_q + (pop ? AW'(1) : AW'(0));
    tail_d  = tail_q + (alloc ? AW'(1) : AW'(0));
    fptr_d  = fptr_q + (rv_fill ? AW'(1) : AW'(0));
    count_d = count_q + CW'(alloc) - CW'(pop);
    pend_d  = pend_q + CW'(alloc) - CW'(rv_fill);
    drop_d  = drop_q - CW'(rv_drop);
    if (flush) begin
      // Every unfilled entry still owes a response; the one arriving now
      // (if it belongs to a live entry) is already accounted for.
      head_d  = '0;
      tail_d  = '0;
      fptr_d  = '0;
      count_d = '0;
      pend_d  = '0;
      drop_d  = drop_q - CW'(rv_drop) + pend_q - CW'(rv_fill);
    end
    state_d = (drop_d != '0) ? DRAIN : RUN;
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      head_q  <= '0;
      tail_q  <= '0;
      fptr_q  <= '0;
      count_q <= '0;
      pend_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      fptr_q  <= fptr_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
    end
  end

  // Fill bits: set on response, cleared on pop; fill and pop never hit the same slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q <= '0;
    end else if (flush) begin
      fill_q <= '0;
    end else begin
      if (rv_fill) fill_q[fptr_q] <= 1'b1;
      if (pop)     fill_q[head_q] <= 1'b0;
    end
  end

  // Entry payload storage, qualified by the fill bits so no reset needed
  always_ff @(posedge clk) begin
    if (alloc)   pc_mem[tail_q]  <= pc_in;
    if (rv_fill) ins_mem[fptr_q] <= imem_rdata;
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: acts as program counter and instruction memory,
// and scoreboards every instruction handed to decode.
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        rst, flush, imem_gnt, imem_rvalid, id_ready;
  logic [31:0] pc_in, imem_rdata;
  logic        pc_en, imem_req, id_valid;
  logic [31:0] imem_addr, id_instr, id_pc;
  logic [2:0]  count;

  always #5 clk = ~clk;

  fetch_queue #(.PC_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_en(pc_en), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_valid(id_valid),
    .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc), .count(count)
  );

  typedef struct {logic [31:0] pc; logic [31:0] ins;} exp_t;
  exp_t        sb[$];
  logic [31:0] mem_q[$];
  int          n_chk = 0, n_pass = 0, n_acc = 0, n_pop = 0;
  logic        hold = 1'b0, expect_first = 1'b0;
  logic [31:0] exp_first, tgt;
  logic        s_req, s_pcen, s_valid;
  logic [2:0]  s_count;

  function automatic logic [31:0] ins_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  // One clock: drive memory response, sample at negedge, update models, advance PC
  task automatic cycle();
    logic [31:0] a;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (!hold && mem_q.size() > 0) begin
      a = mem_q.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = ins_of(a);
    end
    @(negedge clk);
    s_req = imem_req; s_pcen = pc_en; s_valid = id_valid; s_count = count;
    chk("pc_en", s_pcen, (s_req & imem_gnt) | flush);
    if (flush) chk("flush_vld", s_valid, 1'b0);
    if (s_valid) begin
      if (sb.size() == 0) chk("valid_empty", 1'b1, 1'b0);
      else begin
        chk("id_pc", id_pc, sb[0].pc);
        chk("id_instr", id_instr, sb[0].ins);
        if (id_ready) begin
          if (expect_first) begin
            chk("first_pc", id_pc, exp_first);
            expect_first = 1'b0;
          end
          void'(sb.pop_front());
          n_pop++;
        end
      end
    end
    if (rst || flush) sb.delete();
    if (s_req && imem_gnt) begin
      sb.push_back('{pc: pc_in, ins: ins_of(pc_in)});
      mem_q.push_back(pc_in);
      n_acc++;
    end
    @(posedge clk);
    #1;
    if (s_pcen) pc_in = flush ? tgt : pc_in + 32'd4;
  endtask

  task automatic drain();
    int i;
    imem_gnt = 1'b0; id_ready = 1'b1; hold = 1'b0; flush = 1'b0;
    for (i = 0; i < 40; i++) begin
      cycle();
      if (s_count == 0 && mem_q.size() == 0) break;
    end
    if (i == 40) chk("drain_timeout", 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; imem_gnt = 1'b1; id_ready = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; pc_in = 32'hBFC0_0000; tgt = '0;
    @(posedge clk); #1;
    chk("rst_count", count, 0);
    chk("rst_vld", id_valid, 0);
    chk("rst_req", imem_req, 0);
    rst = 1'b0;

    // Streaming: one fetch, one response, one pop per cycle
    id_ready = 1'b1; expect_first = 1'b1; exp_first = 32'hBFC0_0000;
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk("st_pcen", s_pcen, 1);
      chk("st_lat", s_valid, i >= 2);
      if (i >= 3) chk("st_count", s_count, 2);
    end
    chk("st_first_seen", expect_first, 0);
    drain();

    // Backpressure: decode stalled
    imem_gnt = 1'b1; id_ready = 1'b0; n_acc = 0;
    repeat (8) cycle();
    chk("bp_acc", n_acc, 4);
    chk("bp_count", s_count, 4);
    chk("bp_req", s_req, 0);
    chk("bp_pcen", s_pcen, 0);
    n_pop = 0; id_ready = 1'b1;
    cycle();
    id_ready = 1'b0;
    cycle(); cycle();
    chk("bp_pop", n_pop, 1);
    chk("bp_acc2", n_acc, 5);
    chk("bp_count2", s_count, 4);
    drain();

    // Flush with 3 unfilled entries, no coincident response
    hold = 1'b1; imem_gnt = 1'b1;
    repeat (3) cycle();
    imem_gnt = 1'b0; flush = 1'b1; tgt = 32'h8000_0100;
    cycle();
    chk("f3_pcen", s_pcen, 1);
    chk("f3_freq", s_req, 0);
    flush = 1'b0; hold = 1'b0; imem_gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("f3_req", s_req, 0);
      chk("f3_vld", s_valid, 0);
      if (i == 0) chk("f3_count", s_count, 0);
    end
    expect_first = 1'b1; exp_first = 32'h8000_0100;
    cycle();
    chk("f3_resume", s_req, 1);
    repeat (4) cycle();
    chk("f3_first_seen", expect_first, 0);
    drain();

    // Flush coincident with a response, 2 unfilled
    hold = 1'b1; imem_gnt = 1'b1; id_ready = 1'b1;
    repeat (2) cycle();
    imem_gnt = 1'b0; hold = 1'b0; flush = 1'b1; tgt = 32'h8000_0200;
    cycle();
    flush = 1'b0; imem_gnt = 1'b1;
    cycle();
    chk("fc_req", s_req, 0);
    chk("fc_vld", s_valid, 0);
    chk("fc_count", s_count, 0);
    expect_first = 1'b1; exp_first = 32'h8000_0200;
    cycle();
    chk("fc_resume", s_req, 1);
    repeat (4) cycle();
    chk("fc_first_seen", expect_first, 0);
    drain();

    // Flush with every entry filled: no drain needed
    imem_gnt = 1'b1; id_ready = 1'b0;
    repeat (6) cycle();
    chk("ff_count", s_count, 4);
    flush = 1'b1; tgt = 32'h8000_0300;
    cycle();
    flush = 1'b0;
    expect_first = 1'b1; exp_first = 32'h8000_0300;
    cycle();
    chk("ff_count0", s_count, 0);
    chk("ff_req", s_req, 1);
    id_ready = 1'b1;
    repeat (4) cycle();
    chk("ff_first_seen", expect_first, 0);
    drain();

    // Reset while draining two squashed responses
    hold = 1'b1; imem_gnt = 1'b1; id_ready = 1'b1;
    repeat (2) cycle();
    imem_gnt = 1'b0; flush = 1'b1; tgt = 32'h8000_0400;
    cycle();
    flush = 1'b0;
    cycle();
    chk("rd_req", s_req, 0);
    rst = 1'b1;
    #1;
    chk("ra_count", count, 0);
    chk("ra_vld", id_valid, 0);
    chk("ra_req", imem_req, 0);
    repeat (2) cycle();
    rst = 1'b0; hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stray_count", s_count, 0);
      chk("stray_vld", s_valid, 0);
    end
    chk("stray_gone", mem_q.size(), 0);
    imem_gnt = 1'b1; expect_first = 1'b1; exp_first = 32'h8000_0400;
    repeat (6) cycle();
    chk("r_first_seen", expect_first, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter PC_WIDTH, default 32, sets the width of every PC/address port.
REQ-002 Parameter INSTR_WIDTH, default 32, sets the width of instruction data ports.
REQ-003 Parameter DEPTH, default 4, sets queue entries; power of two, >=2.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 pc_in  in  PC_WIDTH  current PC from program counter.
REQ-007 pc_en  out  1  advance/load enable to program counter.
REQ-008 flush  in  1  redirect from execute; same signal drives PC pc_src.
REQ-009 imem_req  out  1  instruction memory fetch request.
REQ-010 imem_addr  out  PC_WIDTH  fetch address.
REQ-011 imem_gnt  in  1  request accepted this cycle.
REQ-012 imem_rvalid  in  1  in-order read response valid.
REQ-013 imem_rdata  in  INSTR_WIDTH  response instruction.
REQ-014 id_valid  out  1  head entry available to decode.
REQ-015 id_ready  in  1  decode accepts head entry.
REQ-016 id_instr  out  INSTR_WIDTH  head instruction.
REQ-017 id_pc  out  PC_WIDTH  PC of head instruction.
REQ-018 count  out  $clog2(DEPTH)+1  allocated entries (filled + awaiting response).

Function
REQ-019 Entries SHALL be allocated in order at request acceptance (imem_req & imem_gnt), storing pc_in; filled in order on imem_rvalid with imem_rdata.
REQ-020 imem_addr SHALL equal pc_in combinationally.
REQ-021 imem_req SHALL be 1 iff state==RUN, flush==0 and count<DEPTH.
REQ-022 pc_en SHALL equal (imem_req & imem_gnt) | flush, so PC advances by 4 per accepted fetch and loads pc_branch on flush.
REQ-023 id_valid SHALL be 1 iff head entry is filled and flush==0; id_instr/id_pc SHALL reflect head entry.
REQ-024 Head SHALL pop on id_valid & id_ready; allocate, fill and pop in the same cycle SHALL all take effect; count = count + alloc - pop.
REQ-025 Response SHALL not bypass queue: earliest id_valid is the cycle after rvalid (1-cycle latency from rvalid).
REQ-026 Pointers SHALL wrap modulo DEPTH; full is count==DEPTH, empty is count==0.
REQ-027 State machine: RUN, DRAIN. Drop counter width $clog2(DEPTH)+1.
REQ-028 flush SHALL clear all entries (count->0) next cycle; drop SHALL load (unfilled entries) - (imem_rvalid this cycle ? 1 : 0) plus any existing drop.
REQ-029 RUN -> DRAIN on flush when loaded drop>0; otherwise remain RUN.
REQ-030 In DRAIN, each imem_rvalid SHALL decrement drop and its data SHALL be discarded; DRAIN -> RUN when drop reaches 0.
REQ-031 In DRAIN, no requests SHALL issue; flush in DRAIN SHALL remain in DRAIN with drop unchanged except rvalid decrement.
REQ-032 imem_rvalid with no unfilled entry and drop==0 SHALL be ignored (protocol violation, no state change).

Reset
REQ-033 rst SHALL asynchronously force: count=0, pointers=0, drop=0, state=RUN, all fill bits=0; hence imem_req=0 only while rst held, id_valid=0.
REQ-034 Reset mid-operation SHALL discard all entries and in-flight tracking; responses arriving after release with no outstanding request fall under REQ-032.

Verification
REQ-035 Stream: gnt=1 every cycle, rvalid 1 cycle after gnt, id_ready=1, pc_in 0xBFC00000 -> id_pc 0xBFC00000, 0xBFC00004, ... consecutive, count steady, pc_en=1 each cycle.
REQ-036 Backpressure: id_ready=0, gnt=1 -> exactly 4 accepted fetches, count=4, imem_req=0 and pc_en=0 thereafter; id_ready=1 one cycle -> one pop, one new fetch.
REQ-037 Flush with 3 unfilled entries, no rvalid same cycle -> pc_en=1, count=0 next cycle, DRAIN with drop=3; next 3 rvalids produce no id_valid; RUN after third; first id_pc equals branch target.
REQ-038 Flush coincident with rvalid and 2 unfilled -> drop=1, that response discarded.
REQ-039 Flush with all entries filled -> remain RUN, count=0, fetching resumes next cycle with imem_req=1.
REQ-040 Assert rst during DRAIN with drop=2 -> count=0, state RUN, id_valid=0 immediately; post-reset stray rvalid ignored.
